// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding an 8N1 UART transmitter.
// Optional message locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        tx
);
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_byte;
  logic [1:0]       last_winner;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic [3:0]       eligible;
  logic             found;
  logic             accept;
  logic             bit_done;

`ifdef UART_ARB_LOCK_EN
  logic locked;
  // While locked, only the owner of the unfinished message may be served.
  assign eligible = locked ? (req_valid & (4'b0001 << last_winner)) : req_valid;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  assign bit_done = (bit_cnt == CNT_W'(BIT_CYCLES - 1));

  // Search starts one past the last winner and wraps back onto it last.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_winner + 2'(k);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign accept    = (state == IDLE) && found && !rst;
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx         = 1'b1;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: begin
        tx = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx = tx_byte[bit_idx];
        if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP:  if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      bit_idx     <= 3'd0;
      tx_byte     <= 8'd0;
      grant       <= 2'd0;
      last_winner <= 2'd3;
`ifdef UART_ARB_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_done) bit_cnt <= '0;
      else                           bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
      else if (state == IDLE)        bit_idx <= 3'd0;

      if (accept) begin
        tx_byte     <= req_data[{winner, 3'b000} +: 8];
        grant       <= winner;
        last_winner <= winner;
`ifdef UART_ARB_LOCK_EN
        locked      <= !req_last[winner];
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter at BIT_CYCLES = 10.
// Lock-mode expectations are selected with UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        tx;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int mark    = 0;
  logic [3:0] seen = 4'b0000;
  logic [7:0] expb;

  uart_tx_arbiter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [31:0] data, input logic [3:0] last);
    req_valid = valid;
    req_data  = data;
    req_last  = last;
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int j);
    if (j < 10)  return 1'b0;
    if (j >= 90) return 1'b1;
    return b[3'(j / 10 - 1)];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0, 4'b0000);
    tick();
    tick();
    check_output("reset tx", tx, 1'b1);
    check_output("reset busy", busy, 1'b0);
    check_output("reset ready", req_ready, 4'b0000);
    check_output("reset grant", grant, 2'd0);
    rst = 1'b0;
  endtask

  task automatic wait_accept(input int budget, output int idx);
    idx = -1;
    #1;
    for (int n = 0; n < budget; n++) begin
      if (req_ready != 4'b0000) begin
        case (req_ready)
          4'b0001: idx = 0;
          4'b0010: idx = 1;
          4'b0100: idx = 2;
          4'b1000: idx = 3;
          default: idx = -2;
        endcase
        break;
      end
      tick();
    end
  endtask

  task automatic accept_step(input int exp_idx, input string tag);
    int idx;
    wait_accept(300, idx);
    check_output({tag, " winner"}, idx, exp_idx);
    acc_cyc = cyc;
    seen |= req_ready;
    tick();
    check_output({tag, " grant"}, grant, exp_idx);
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int j = 0; j < 100; j++) begin
      check_output($sformatf("%s tx[%0d]", tag, j), tx, exp_tx(b, j));
      check_output($sformatf("%s busy[%0d]", tag, j), busy, 1'b1);
      check_output($sformatf("%s ready[%0d]", tag, j), req_ready, 4'b0000);
      tick();
    end
    check_output({tag, " idle tx"}, tx, 1'b1);
    check_output({tag, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0, 4'b0000);

    // Single byte, accepted in the first cycle out of reset
    do_reset();
    apply_stimulus(4'b0001, 32'h0000_0048, 4'b0000);
    #1;
    check_output("single first-cycle ready", req_ready, 4'b0001);
    accept_step(0, "single");
    apply_stimulus(4'b0000, 32'hFFFF_FFFF, 4'b0000);
    check_frame(8'h48, "single");

    // All four contending continuously
    do_reset();
    apply_stimulus(4'b1111, 32'h1312_1110, 4'b0000);
    for (int f = 0; f < 5; f++) begin
      accept_step(f % 4, $sformatf("contend%0d", f));
      if (f > 0) check_output($sformatf("contend%0d spacing", f), acc_cyc - prev_acc, 101);
      prev_acc = acc_cyc;
      expb = 8'h10 + 8'(f % 4);
      check_frame(expb, $sformatf("contend%0d", f));
    end

    // Only requesters 1 and 3 pending
    do_reset();
    seen = 4'b0000;
    apply_stimulus(4'b1010, 32'hA300_A100, 4'b0000);
    for (int f = 0; f < 4; f++) begin
      accept_step((f % 2 == 0) ? 1 : 3, $sformatf("fair%0d", f));
      check_frame((f % 2 == 0) ? 8'hA1 : 8'hA3, $sformatf("fair%0d", f));
    end
    check_output("fair idle requesters never ready", seen & 4'b0101, 4'b0000);

    // Reset in the middle of DATA bit 3
    do_reset();
    apply_stimulus(4'b0001, 32'h0000_0055, 4'b0000);
    accept_step(0, "abort");
    apply_stimulus(4'b0000, 32'h0, 4'b0000);
    repeat (45) tick();
    check_output("abort pre-reset bit3", tx, 1'b0);
    rst = 1'b1;
    apply_stimulus(4'b0101, 32'h0077_00A5, 4'b0000);
    tick();
    check_output("abort tx", tx, 1'b1);
    check_output("abort busy", busy, 1'b0);
    check_output("abort ready", req_ready, 4'b0000);
    check_output("abort grant", grant, 2'd0);
    rst = 1'b0;
    mark = cyc;
    accept_step(0, "after-abort");
    check_output("after-abort immediate", acc_cyc, mark);
    apply_stimulus(4'b0000, 32'h0, 4'b0000);
    check_frame(8'hA5, "after-abort");

    // Requester 2 sends "Hi" while requester 0 waits
    do_reset();
    apply_stimulus(4'b0100, 32'h0048_0000, 4'b0000);
    accept_step(2, "msg H");
    apply_stimulus(4'b0101, 32'h0069_0030, 4'b0100);
    check_frame(8'h48, "msg H");
`ifdef UART_ARB_LOCK_EN
    accept_step(2, "msg i");
    apply_stimulus(4'b0001, 32'h0000_0030, 4'b0000);
    check_frame(8'h69, "msg i");
    accept_step(0, "msg r0");
    apply_stimulus(4'b0000, 32'h0, 4'b0000);
    check_frame(8'h30, "msg r0");
`else
    accept_step(0, "msg r0");
    apply_stimulus(4'b0100, 32'h0069_0000, 4'b0100);
    check_frame(8'h30, "msg r0");
    accept_step(2, "msg i");
    apply_stimulus(4'b0000, 32'h0, 4'b0000);
    check_frame(8'h69, "msg i");
`endif

    // Data changes during the frame must not reach the line
    do_reset();
    apply_stimulus(4'b1000, 32'hC300_0000, 4'b0000);
    accept_step(3, "hold");
    apply_stimulus(4'b0000, 32'h3C00_0000, 4'b0000);
    check_frame(8'hC3, "hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
